// File: rtl/sha256_w_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_w_stream_if
// Purpose  : Memory read port and W-word valid/ready stream of sha256_w_stream.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_w_stream_if #(
   parameter int ADDR_W = 16
) ();
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [31:0]       mem_read_data;
   logic              w_valid;
   logic              w_ready;
   logic [31:0]       w_data;
   logic [5:0]        w_idx;

   modport master (
      output mem_addr, mem_we, w_valid, w_data, w_idx,
      input  mem_read_data, w_ready
   );

   modport slave (
      input  mem_addr, mem_we, w_valid, w_data, w_idx,
      output mem_read_data, w_ready
   );
endinterface
`default_nettype wire

// File: rtl/sha256_w_stream.sv
`default_nettype none
// ============================================================================
// Module   : sha256_w_stream
// Purpose  : Fetches a 16-word block and streams SHA-256 schedule words W[0..63].
//            Optional NONCE_INSERT_EN replaces block word NONCE_IDX with a nonce.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_w_stream #(
   parameter int ADDR_W = 16
`ifdef NONCE_INSERT_EN
   , parameter int NONCE_IDX = 3
`endif
) (
   input  wire              clk,
   input  wire              reset_n,
   input  wire              start,
   input  wire [ADDR_W-1:0] msg_addr,
`ifdef NONCE_INSERT_EN
   input  wire [31:0]       nonce,
`endif
   sha256_w_stream_if.master bus,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic [4:0]        r_cnt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_window [16];
   logic              r_w_valid;
   logic [31:0]       r_w_data;
   logic [5:0]        r_w_idx;
   logic [6:0]        r_t;
   logic [31:0]       w_new_word;
   logic [31:0]       w_fetch_word;
   logic [3:0]        w_wr_idx;
   logic              w_load;

   function automatic logic [31:0] f_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] f_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   assign w_new_word = r_window[0] + f_s0(r_window[1]) + r_window[9] + f_s1(r_window[14]);
   assign w_load     = !r_w_valid || bus.w_ready;
   // Read data lags the address by one cycle, so fetch cycle i fills entry i-1.
   assign w_wr_idx   = 4'(r_cnt - 5'd1);

`ifdef NONCE_INSERT_EN
   logic [31:0] r_nonce;
   assign w_fetch_word = (w_wr_idx == 4'(NONCE_IDX)) ? r_nonce : bus.mem_read_data;
`else
   assign w_fetch_word = bus.mem_read_data;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next_state = S_FETCH;
         S_FETCH:  if (r_cnt == 5'd16) w_next_state = S_STREAM;
         // Leave only after the W[63] transfer has dropped w_valid.
         S_STREAM: if (r_t[6] && !r_w_valid) w_next_state = S_DONE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = (r_state == S_DONE);
   end

   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_we   = 1'b0;
   assign bus.w_valid  = r_w_valid;
   assign bus.w_data   = r_w_data;
   assign bus.w_idx    = r_w_idx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= '0;
         r_mem_addr <= '0;
         r_w_valid  <= 1'b0;
         r_w_data   <= '0;
         r_w_idx    <= '0;
         r_t        <= '0;
`ifdef NONCE_INSERT_EN
         r_nonce    <= '0;
`endif
         for (int i = 0; i < 16; i++) r_window[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mem_addr <= msg_addr;
                  r_cnt      <= '0;
                  r_t        <= '0;
`ifdef NONCE_INSERT_EN
                  r_nonce    <= nonce;
`endif
               end
            end
            S_FETCH: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt < 5'd15) r_mem_addr <= r_mem_addr + ADDR_W'(1);
               if (r_cnt != 5'd0) r_window[w_wr_idx] <= w_fetch_word;
            end
            S_STREAM: begin
               if (w_load) begin
                  if (r_t[6]) begin
                     r_w_valid <= 1'b0;
                  end else begin
                     r_w_valid <= 1'b1;
                     r_w_idx   <= r_t[5:0];
                     r_t       <= r_t + 7'd1;
                     if (r_t[5:4] == 2'b00) begin
                        r_w_data <= r_window[r_t[3:0]];
                     end else begin
                        r_w_data <= w_new_word;
                        for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
                        r_window[15] <= w_new_word;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sha256_w_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_w_stream
// Purpose  : Self-checking bench for sha256_w_stream against an array-based
//            SHA-256 schedule model; honours NONCE_INSERT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_w_stream;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] msg_addr;
   logic        busy;
   logic        done;
`ifdef NONCE_INSERT_EN
   logic [31:0] nonce;
`endif

   always #5 clk = ~clk;

   sha256_w_stream_if #(.ADDR_W(16)) bus ();

   sha256_w_stream dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .msg_addr (msg_addr),
`ifdef NONCE_INSERT_EN
      .nonce    (nonce),
`endif
      .bus      (bus.master),
      .busy     (busy),
      .done     (done)
   );

   logic [31:0] mem [0:65535];
   always @(posedge clk) bus.mem_read_data <= mem[bus.mem_addr];

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] blk  [16];
   logic [31:0] refw [64];
   logic [31:0] got  [64];

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_ref();
      for (int t = 0; t < 16; t++) refw[t] = blk[t];
`ifdef NONCE_INSERT_EN
      refw[3] = nonce;
`endif
      for (int t = 16; t < 64; t++)
         refw[t] = ssig1(refw[t-2]) + refw[t-7] + ssig0(refw[t-15]) + refw[t-16];
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"},     64'(busy),          64'd0);
      chk({tag, "_done"},     64'(done),          64'd0);
      chk({tag, "_w_valid"},  64'(bus.w_valid),   64'd0);
      chk({tag, "_w_data"},   64'(bus.w_data),    64'd0);
      chk({tag, "_w_idx"},    64'(bus.w_idx),     64'd0);
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr),  64'd0);
   endtask

   // rmode: 0 = ready always high, 1 = ready pattern 1,0,0, 2 = random ready.
   task automatic run_block(input logic [15:0] base, input int rmode, input bit timing,
                            input bit poke, input int abort_at);
      int          cyc, ngot, first_v, done_cyc, ndone, post;
      bit          prev_stall, we_bad, finished;
      logic [31:0] hd;
      logic [5:0]  hi;
      ngot = 0; first_v = -1; done_cyc = -1; ndone = 0; post = 0;
      prev_stall = 1'b0; we_bad = 1'b0; finished = 1'b0; hd = '0; hi = '0;
      for (int i = 0; i < 16; i++) mem[16'(base + 16'(i))] = blk[i];
      build_ref();
      @(negedge clk);
      start = 1'b1; msg_addr = base;
      @(negedge clk);
      start = 1'b0; msg_addr = 16'($urandom);
      cyc = 0;
      while (!finished && cyc < 400) begin
         case (rmode)
            0:       bus.w_ready = 1'b1;
            1:       bus.w_ready = (cyc % 3 == 0);
            default: bus.w_ready = 1'($urandom);
         endcase
         start = poke && (cyc == 40 || done);
         if (bus.mem_we !== 1'b0) we_bad = 1'b1;
         if (cyc < 16) chk("mem_addr", 64'(bus.mem_addr), 64'(16'(base + 16'(cyc))));
         if (bus.w_valid) begin
            if (first_v < 0) first_v = cyc;
            if (prev_stall) begin
               chk("hold_data", 64'(bus.w_data), 64'(hd));
               chk("hold_idx",  64'(bus.w_idx),  64'(hi));
            end else if (ngot < 64) begin
               chk("w_idx",  64'(bus.w_idx),  64'(ngot));
               chk("w_data", 64'(bus.w_data), 64'(refw[ngot]));
               got[ngot] = bus.w_data;
            end else begin
               chk("extra_word", 64'(ngot + 1), 64'd64);
            end
            if (abort_at >= 0 && !prev_stall && int'(bus.w_idx) == abort_at) begin
               reset_n = 1'b0;
               @(posedge clk); #1;
               chk_zero_outputs("abort");
               @(negedge clk);
               reset_n = 1'b1;
               start   = 1'b0;
               return;
            end
            prev_stall = !bus.w_ready;
            hd = bus.w_data;
            hi = bus.w_idx;
            if (bus.w_ready) ngot++;
         end else begin
            prev_stall = 1'b0;
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            chk("busy_in_done", 64'(busy), 64'd1);
         end
         if (ndone > 0) post++;
         if (post == 3) finished = 1'b1;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("finished_in_budget", 64'(finished), 64'd1);
      chk("word_count",  64'(ngot),   64'd64);
      chk("done_pulses", 64'(ndone),  64'd1);
      chk("busy_after",  64'(busy),   64'd0);
      chk("mem_we_zero", 64'(we_bad), 64'd0);
      if (timing) begin
         chk("first_valid_cycle", 64'(first_v),  64'd18);
         chk("done_cycle",        64'(done_cyc), 64'd83);
      end
   endtask

   task automatic load_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   task automatic load_random();
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; msg_addr = '0; bus.w_ready = 1'b0;
`ifdef NONCE_INSERT_EN
      nonce = 32'hDEADBEEF;
`endif
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      chk("reset_mem_we", 64'(bus.mem_we), 64'd0);
      reset_n = 1'b1;

      load_abc();
      run_block(16'h0100, 0, 1'b1, 1'b0, -1);
`ifndef NONCE_INSERT_EN
      chk("abc_W16", 64'(got[16]), 64'h61626380);
      chk("abc_W17", 64'(got[17]), 64'h000F0000);
`endif

      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      run_block(16'h2000, 0, 1'b1, 1'b0, -1);

      load_abc();
      run_block(16'h0480, 1, 1'b0, 1'b0, -1);
`ifndef NONCE_INSERT_EN
      chk("stall_W16", 64'(got[16]), 64'h61626380);
      chk("stall_W17", 64'(got[17]), 64'h000F0000);
`endif

      load_random();
      run_block(16'hFFF8, 0, 1'b1, 1'b0, -1);

      load_random();
      run_block(16'h3000, 0, 1'b0, 1'b0, 20);
      load_random();
      run_block(16'h3100, 2, 1'b0, 1'b1, -1);

`ifdef NONCE_INSERT_EN
      load_random();
      blk[3] = 32'h01234567;
      run_block(16'h4000, 0, 1'b1, 1'b1, -1);
      chk("nonce_W3", 64'(got[3]), 64'hDEADBEEF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
